// File: rtl/occamy_ecc_irq_servicer.sv
// ECC interrupt servicer: reads and clears INTR_STATE over a simple register bus, counts events.
// Define OCCAMY_ECC_SERVICER_TIMEOUT_EN to abort requests that stay unanswered for 255 cycles.
module occamy_ecc_irq_servicer #(
   parameter int unsigned          AddrWidth     = 32,
   parameter logic [AddrWidth-1:0] BaseAddr      = '0,
   parameter logic [AddrWidth-1:0] IntrStateOff  = '0,
   parameter logic [AddrWidth-1:0] IntrEnableOff = AddrWidth'(32'h4),
   parameter int unsigned          CntWidth      = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 intr_correctable_i,
   input  logic                 intr_uncorrectable_i,
   output logic                 reg_valid_o,
   output logic                 reg_write_o,
   output logic [AddrWidth-1:0] reg_addr_o,
   output logic [31:0]          reg_wdata_o,
   output logic [3:0]           reg_wstrb_o,
   input  logic                 reg_ready_i,
   input  logic [31:0]          reg_rdata_i,
   input  logic                 reg_error_i,
   input  logic                 cnt_clr_i,
   output logic [CntWidth-1:0]  corr_cnt_o,
   output logic [CntWidth-1:0]  uncorr_cnt_o,
   output logic                 uncorr_alert_o,
   output logic                 bus_err_o,
   output logic                 busy_o
);

   typedef enum logic [2:0] {StInit, StIdle, StRead, StClear, StHold, StErr} state_e;

   localparam logic [CntWidth-1:0] CntMax = '1;

   state_e     state;
   logic [1:0] pend;
   logic       hold_cnt;
`ifdef OCCAMY_ECC_SERVICER_TIMEOUT_EN
   logic [7:0] tmo;
`endif

   logic unused_rdata;
   assign unused_rdata = ^reg_rdata_i[31:2];

   assign busy_o = (state != StIdle);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state          <= StInit;
         pend           <= 2'b00;
         hold_cnt       <= 1'b0;
         reg_valid_o    <= 1'b0;
         reg_write_o    <= 1'b0;
         reg_addr_o     <= '0;
         reg_wdata_o    <= '0;
         reg_wstrb_o    <= '0;
         corr_cnt_o     <= '0;
         uncorr_cnt_o   <= '0;
         uncorr_alert_o <= 1'b0;
         bus_err_o      <= 1'b0;
`ifdef OCCAMY_ECC_SERVICER_TIMEOUT_EN
         tmo            <= '0;
`endif
      end else begin
         uncorr_alert_o <= 1'b0;
         case (state)
            StInit, StRead, StClear: begin
               // valid is always low on entry, which yields the idle gap between requests
               if (!reg_valid_o) begin
                  reg_valid_o <= 1'b1;
`ifdef OCCAMY_ECC_SERVICER_TIMEOUT_EN
                  tmo         <= '0;
`endif
                  if (state == StInit) begin
                     reg_write_o <= 1'b1;
                     reg_addr_o  <= BaseAddr + IntrEnableOff;
                     reg_wdata_o <= 32'h3;
                     reg_wstrb_o <= 4'hF;
                  end else if (state == StRead) begin
                     reg_write_o <= 1'b0;
                     reg_addr_o  <= BaseAddr + IntrStateOff;
                     reg_wdata_o <= '0;
                     reg_wstrb_o <= 4'h0;
                  end else begin
                     reg_write_o <= 1'b1;
                     reg_addr_o  <= BaseAddr + IntrStateOff;
                     reg_wdata_o <= {30'b0, pend};
                     reg_wstrb_o <= 4'h1;
                  end
               end else if (reg_ready_i) begin
                  reg_valid_o <= 1'b0;
                  if (reg_error_i) begin
                     state <= StErr;
                  end else if (state == StInit) begin
                     state <= StIdle;
                  end else if (state == StRead) begin
                     pend  <= reg_rdata_i[1:0];
                     state <= (reg_rdata_i[1:0] != 2'b00) ? StClear : StIdle;
                  end else begin
                     if (pend[0] && corr_cnt_o != CntMax) corr_cnt_o <= corr_cnt_o + 1'b1;
                     if (pend[1] && uncorr_cnt_o != CntMax) uncorr_cnt_o <= uncorr_cnt_o + 1'b1;
                     uncorr_alert_o <= pend[1];
                     hold_cnt       <= 1'b0;
                     state          <= StHold;
                  end
               end
`ifdef OCCAMY_ECC_SERVICER_TIMEOUT_EN
               // tmo reaches 255 on the same edge that valid drops
               else if (tmo == 8'd254) begin
                  reg_valid_o <= 1'b0;
                  tmo         <= tmo + 8'd1;
                  state       <= StErr;
               end else begin
                  tmo <= tmo + 8'd1;
               end
`endif
            end
            StIdle: begin
               if (intr_correctable_i || intr_uncorrectable_i) state <= StRead;
            end
            StHold: begin
               hold_cnt <= ~hold_cnt;
               if (hold_cnt) state <= StIdle;
            end
            StErr: begin
               bus_err_o   <= 1'b1;
               reg_valid_o <= 1'b0;
               state       <= StIdle;
            end
            default: state <= StIdle;
         endcase
         // clear wins over any increment made above in the same cycle
         if (cnt_clr_i) begin
            corr_cnt_o   <= '0;
            uncorr_cnt_o <= '0;
         end
      end
   end

endmodule

// File: tb/tb_occamy_ecc_irq_servicer.sv
// Randomized bench for occamy_ecc_irq_servicer: bus responder plus an event-level counter model.
// Counters are instantiated 4 bits wide so saturation is reachable in a short run.
module tb_occamy_ecc_irq_servicer;

   localparam int unsigned CW   = 4;
   localparam int          CMax = 15;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          intr_c = 1'b0, intr_u = 1'b0;
   logic          reg_valid, reg_write;
   logic [31:0]   reg_addr, reg_wdata;
   logic [3:0]    reg_wstrb;
   logic          reg_ready = 1'b0;
   logic [31:0]   reg_rdata = '0;
   logic          reg_error = 1'b0;
   logic          cnt_clr = 1'b0;
   logic [CW-1:0] corr_cnt, uncorr_cnt;
   logic          uncorr_alert, bus_err, busy;

   occamy_ecc_irq_servicer #(
      .AddrWidth(32), .BaseAddr(32'h0), .IntrStateOff(32'h0), .IntrEnableOff(32'h4),
      .CntWidth(CW)
   ) dut (
      .clk_i(clk), .rst_i(rst),
      .intr_correctable_i(intr_c), .intr_uncorrectable_i(intr_u),
      .reg_valid_o(reg_valid), .reg_write_o(reg_write), .reg_addr_o(reg_addr),
      .reg_wdata_o(reg_wdata), .reg_wstrb_o(reg_wstrb),
      .reg_ready_i(reg_ready), .reg_rdata_i(reg_rdata), .reg_error_i(reg_error),
      .cnt_clr_i(cnt_clr), .corr_cnt_o(corr_cnt), .uncorr_cnt_o(uncorr_cnt),
      .uncorr_alert_o(uncorr_alert), .bus_err_o(bus_err), .busy_o(busy)
   );

   always #5 clk = ~clk;

   int n_cmp = 0, n_bad = 0;
   int corr_m = 0, uncorr_m = 0, alerts_m = 0, alerts_seen = 0;
   bit bus_err_m = 1'b0;

   always @(negedge clk) if (uncorr_alert === 1'b1) alerts_seen++;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_model();
      check_eq("corr_cnt", 64'(corr_cnt), 64'(corr_m));
      check_eq("uncorr_cnt", 64'(uncorr_cnt), 64'(uncorr_m));
      check_eq("bus_err", 64'(bus_err), 64'(bus_err_m));
      check_eq("alert_count", 64'(alerts_seen), 64'(alerts_m));
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy !== 1'b0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check_eq("idle", 64'(busy), 64'(0));
   endtask

   // Responder: wait for a request, check it, hold it for `delay` cycles, then acknowledge.
   task automatic bus_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input logic [31:0] rdata, input bit err,
                          input int delay, input bit clr_at_ack);
      int n = 0;
      while (reg_valid !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check_eq("req_valid", 64'(reg_valid), 64'(1));
      check_eq("req_write", 64'(reg_write), 64'(wr));
      check_eq("req_addr", 64'(reg_addr), 64'(addr));
      if (wr) check_eq("req_data", {reg_wdata, 28'b0, reg_wstrb}, {wdata, 28'b0, wstrb});
      for (int i = 0; i < delay; i++) begin
         @(negedge clk);
         check_eq("req_hold", 64'({reg_valid, reg_write, reg_addr}), 64'({1'b1, wr, addr}));
      end
      reg_ready = 1'b1;
      reg_rdata = rdata;
      reg_error = err;
      cnt_clr   = clr_at_ack;
      @(negedge clk);
      reg_ready = 1'b0;
      reg_rdata = '0;
      reg_error = 1'b0;
      cnt_clr   = 1'b0;
      check_eq("req_drop", 64'(reg_valid), 64'(0));
   endtask

   // One interrupt episode: read INTR_STATE, clear what was pending, update the model.
   task automatic service(input logic [1:0] pend, input bit rd_err, input bit cl_err,
                          input bit clr_same);
      {intr_u, intr_c} = (pend != 2'b00) ? pend : 2'b01;
      @(negedge clk);
      bus_txn(1'b0, 32'h0, 32'h0, 4'h0, {30'($urandom), pend}, rd_err, $urandom_range(0, 3), 1'b0);
      intr_c = 1'b0;
      intr_u = 1'b0;
      if (rd_err) begin
         bus_err_m = 1'b1;
         wait_idle();
      end else if (pend == 2'b00) begin
         wait_idle();
      end else begin
         bus_txn(1'b1, 32'h0, {30'b0, pend}, 4'h1, $urandom, cl_err, $urandom_range(0, 3),
                 clr_same);
         if (clr_same) begin
            corr_m   = 0;
            uncorr_m = 0;
         end
         if (cl_err) begin
            bus_err_m = 1'b1;
            wait_idle();
         end else begin
            if (!clr_same) begin
               if (pend[0] && corr_m < CMax) corr_m++;
               if (pend[1] && uncorr_m < CMax) uncorr_m++;
            end
            if (pend[1]) alerts_m++;
            check_eq("alert_pulse", 64'(uncorr_alert), 64'(pend[1]));
            check_eq("hold1_busy", 64'(busy), 64'(1));
            @(negedge clk);
            check_eq("hold2_busy", 64'(busy), 64'(1));
            check_eq("alert_low", 64'(uncorr_alert), 64'(0));
            @(negedge clk);
            check_eq("hold_done", 64'(busy), 64'(0));
         end
      end
      check_model();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      int hi;
      // reset state
      repeat (2) @(negedge clk);
      check_eq("rst_bus", 64'({reg_valid, reg_write, reg_addr, reg_wdata, reg_wstrb}), 64'(0));
      check_eq("rst_state", 64'({corr_cnt, uncorr_cnt, uncorr_alert, bus_err, busy}), 64'(1));
      rst = 1'b0;
      bus_txn(1'b1, 32'h4, 32'h3, 4'hF, 32'h0, 1'b0, 2, 1'b0);
      check_eq("init_idle", 64'(busy), 64'(0));

      // directed episodes: correctable, both, read error then recovery
      service(2'b01, 1'b0, 1'b0, 1'b0);
      service(2'b11, 1'b0, 1'b0, 1'b0);
      service(2'b01, 1'b1, 1'b0, 1'b0);
      service(2'b10, 1'b0, 1'b0, 1'b0);

      // randomized episodes with occasional idle-time counter clears
      for (int k = 0; k < 40; k++) begin
         service(2'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), 1'b0);
         if ($urandom_range(0, 9) == 0) begin
            cnt_clr = 1'b1;
            @(negedge clk);
            cnt_clr  = 1'b0;
            corr_m   = 0;
            uncorr_m = 0;
            check_model();
         end
      end

      // saturation, then clear colliding with an increment
      for (int k = 0; k < CMax + 2; k++) service(2'b01, 1'b0, 1'b0, 1'b0);
      check_eq("corr_sat", 64'(corr_cnt), 64'(CMax));
      service(2'b11, 1'b0, 1'b0, 1'b1);

      // interrupt raised during CLEAR is picked up after HOLD
      intr_c = 1'b1;
      @(negedge clk);
      bus_txn(1'b0, 32'h0, 32'h0, 4'h0, 32'h1, 1'b0, 1, 1'b0);
      intr_c = 1'b0;
      intr_u = 1'b1;
      bus_txn(1'b1, 32'h0, 32'h1, 4'h1, 32'h0, 1'b0, 1, 1'b0);
      if (corr_m < CMax) corr_m++;
      bus_txn(1'b0, 32'h0, 32'h0, 4'h0, 32'h2, 1'b0, 0, 1'b0);
      intr_u = 1'b0;
      bus_txn(1'b1, 32'h0, 32'h2, 4'h1, 32'h0, 1'b0, 0, 1'b0);
      if (uncorr_m < CMax) uncorr_m++;
      alerts_m++;
      wait_idle();
      check_model();

      // responder never answers
      intr_c = 1'b1;
      hi = 0;
      while (reg_valid !== 1'b1 && hi < 40) begin
         @(negedge clk);
         hi++;
      end
      intr_c = 1'b0;
      hi = 0;
      for (int i = 0; i < 300; i++) begin
         if (reg_valid === 1'b1) hi++;
         @(negedge clk);
      end
`ifdef OCCAMY_ECC_SERVICER_TIMEOUT_EN
      check_eq("tmo_len", 64'(hi), 64'(255));
      check_eq("tmo_valid", 64'(reg_valid), 64'(0));
      bus_err_m = 1'b1;
`else
      check_eq("no_tmo_len", 64'(hi), 64'(300));
      check_eq("no_tmo_valid", 64'(reg_valid), 64'(1));
      reg_ready = 1'b1;
      @(negedge clk);
      reg_ready = 1'b0;
`endif
      wait_idle();
      check_model();

      // reset in the middle of a read
      intr_u = 1'b1;
      hi = 0;
      while (reg_valid !== 1'b1 && hi < 40) begin
         @(negedge clk);
         hi++;
      end
      rst = 1'b1;
      @(negedge clk);
      check_eq("mid_rst_valid", 64'(reg_valid), 64'(0));
      check_eq("mid_rst_busy", 64'(busy), 64'(1));
      intr_u    = 1'b0;
      rst       = 1'b0;
      corr_m    = 0;
      uncorr_m  = 0;
      bus_err_m = 1'b0;
      bus_txn(1'b1, 32'h4, 32'h3, 4'hF, 32'h0, 1'b0, 0, 1'b0);
      wait_idle();
      check_model();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/occamy_ecc_irq_servicer.md
OCCAMY_ECC_IRQ_SERVICER -- requirements
Module: occamy_ecc_irq_servicer

Interface
REQ-001 SHALL take parameters (name, default, meaning), one per line:
- AddrWidth, 32, register-bus address width.
- BaseAddr, 32'h0, base address of the SoC control register file.
- IntrStateOff, 32'h0, offset of INTR_STATE (W1C; bit0 correctable, bit1 uncorrectable).
- IntrEnableOff, 32'h4, offset of INTR_ENABLE.
- CntWidth, 16, width of each error counter.
REQ-002 SHALL have ports (name, direction, width, meaning), one per line:
- clk_i, in, 1, sole clock; all state changes on its rising edge.
- rst_i, in, 1, reset; synchronous, active-high.
- intr_correctable_i, in, 1, level interrupt from the SoC control block.
- intr_uncorrectable_i, in, 1, level interrupt from the SoC control block.
- reg_valid_o, out, 1, register-bus request valid.
- reg_write_o, out, 1, 1 = write, 0 = read.
- reg_addr_o, out, AddrWidth, request address.
- reg_wdata_o, out, 32, write data.
- reg_wstrb_o, out, 4, write strobes.
- reg_ready_i, in, 1, response valid / request accepted.
- reg_rdata_i, in, 32, read data.
- reg_error_i, in, 1, response error.
- cnt_clr_i, in, 1, synchronous clear of both counters.
- corr_cnt_o, out, CntWidth, serviced correctable events.
- uncorr_cnt_o, out, CntWidth, serviced uncorrectable events.
- uncorr_alert_o, out, 1, one-cycle pulse per serviced uncorrectable event.
- bus_err_o, out, 1, sticky bus-error flag.
- busy_o, out, 1, high whenever state is not IDLE.

Function
REQ-003 SHALL act as the register-bus initiator: hold valid, write, addr, wdata and wstrb stable from assertion until the cycle reg_ready_i=1, and deassert valid the following cycle.
REQ-004 SHALL issue at most one transaction at a time, with at least one idle cycle between transactions.
REQ-005 SHALL use FSM states INIT, IDLE, READ, CLEAR, HOLD, ERR.
REQ-006 INIT SHALL write 32'h3 with wstrb 4'hF to BaseAddr+IntrEnableOff; on ready it goes to IDLE (or to ERR if reg_error_i=1).
REQ-007 IDLE SHALL go to READ in the cycle after either interrupt input is 1.
REQ-008 READ SHALL read BaseAddr+IntrStateOff; on ready it captures reg_rdata_i[1:0] into pend, then goes to CLEAR if pend is nonzero, to IDLE if pend is zero, or to ERR if reg_error_i=1.
REQ-009 CLEAR SHALL write {30'b0,pend} with wstrb 4'h1 to BaseAddr+IntrStateOff; on ready without error it increments the counters for each set bit in pend and goes to HOLD.
REQ-010 HOLD SHALL last exactly 2 cycles to absorb interrupt-deassert latency, then go to IDLE.
REQ-011 ERR SHALL set bus_err_o, drop valid, and go to IDLE the next cycle; bus_err_o clears only on reset.
REQ-012 Counters SHALL saturate at all-ones and never wrap.
REQ-013 cnt_clr_i SHALL take priority over a same-cycle increment: the counter reads 0 the next cycle.
REQ-014 uncorr_alert_o SHALL pulse in the cycle after a successful CLEAR with pend[1]=1.
REQ-015 An interrupt that arrives during READ/CLEAR/HOLD SHALL NOT be lost: IDLE re-samples the level inputs.

Reset
REQ-016 While rst_i=1 the block SHALL enter INIT with reg_valid_o=0, reg_write_o=0, reg_addr_o=0, reg_wdata_o=0, reg_wstrb_o=0, counters 0, uncorr_alert_o=0, bus_err_o=0, busy_o=1, and pend=0.
REQ-017 Reset asserted mid-transaction SHALL drop reg_valid_o the next cycle and restart at INIT.

Configuration
REQ-018 With OCCAMY_ECC_SERVICER_TIMEOUT_EN defined, an 8-bit counter SHALL count cycles while valid is held without ready; when it reaches 255, valid drops and the FSM goes to ERR.
REQ-019 Without OCCAMY_ECC_SERVICER_TIMEOUT_EN, the block SHALL wait for ready indefinitely and contain no timeout logic.

Verification
REQ-020 Release reset, responder ready after 2 cycles -> one write of 0x3, wstrb F, to 0x4, then busy_o=0.
REQ-021 Pulse intr_correctable_i, read returns 0x1 -> write 0x1 to 0x0, corr_cnt_o=1, uncorr_cnt_o=0, 2 HOLD cycles, then IDLE.
REQ-022 Read returns 0x3 -> write 0x3, both counters +1, uncorr_alert_o high for exactly 1 cycle.
REQ-023 reg_error_i=1 on the READ response -> no CLEAR issued, bus_err_o=1 persists, next interrupt still serviced.
REQ-024 Preload corr_cnt_o=16'hFFFF, then service a correctable event -> stays 16'hFFFF; cnt_clr_i in the same cycle as an increment -> 0.
REQ-025 With OCCAMY_ECC_SERVICER_TIMEOUT_EN, hold reg_ready_i=0 -> valid drops after 255 cycles and bus_err_o=1; without the macro, valid stays high.
